// File: rtl/arbitro_turnos_pkg.sv
// Shared definitions for the two-player match controller: state codes,
// BCD digit width and the saturating two-digit BCD increment.
package arbitro_turnos_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        PREPARA  = 4'd1,
        NOVA     = 4'd2,
        ESPERA   = 4'd3,
        REGISTRA = 4'd4,
        COMPARA  = 4'd5,
        ATUALIZA = 4'd6,
        TROCA    = 4'd7,
        FIM      = 4'd8
    } estado_t;

    // {tens,units} + 1, holding at 99
    function automatic logic [2*BCD_W-1:0] bcd_inc_sat(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] dez;
        logic [BCD_W-1:0] uni;
        dez = v[2*BCD_W-1:BCD_W];
        uni = v[BCD_W-1:0];
        if (dez == BCD_W'(9) && uni == BCD_W'(9)) begin
            return v;
        end
        if (uni == BCD_W'(9)) begin
            uni = '0;
            dez = dez + BCD_W'(1);
        end else begin
            uni = uni + BCD_W'(1);
        end
        return {dez, uni};
    endfunction

endpackage

// File: rtl/arbitro_turnos_if.sv
// Player-request and datapath move/control signals of the match controller.
// master = players + datapath side, slave = the arbiter.
interface arbitro_turnos_if;
    logic       jog1_req;
    logic [2:0] jog1_fileira;
    logic [2:0] jog1_coluna;
    logic       jog1_ack;
    logic       jog2_req;
    logic [2:0] jog2_fileira;
    logic [2:0] jog2_coluna;
    logic       jog2_ack;
    logic       acertou;
    logic [2:0] jogadaLinha;
    logic [2:0] jogadaColuna;
    logic       registraR;
    logic       geraNova;
    logic       zeraG;

    modport master (
        output jog1_req, jog1_fileira, jog1_coluna,
        output jog2_req, jog2_fileira, jog2_coluna,
        output acertou,
        input  jog1_ack, jog2_ack,
        input  jogadaLinha, jogadaColuna, registraR, geraNova, zeraG
    );

    modport slave (
        input  jog1_req, jog1_fileira, jog1_coluna,
        input  jog2_req, jog2_fileira, jog2_coluna,
        input  acertou,
        output jog1_ack, jog2_ack,
        output jogadaLinha, jogadaColuna, registraR, geraNova, zeraG
    );
endinterface

// File: rtl/arbitro_turnos_contador_bcd2.sv
// Two-digit BCD score counter, sync clear over increment, saturating at 99.
// Value updates on the clock edge after clr_i/inc_i; no backpressure.
module contador_bcd2
    import arbitro_turnos_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [2*BCD_W-1:0]   valor_o
);

    logic [2*BCD_W-1:0] valor_q;
    logic [2*BCD_W-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (clr_i) begin
            valor_d = '0;
        end else if (inc_i) begin
            valor_d = bcd_inc_sat(valor_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_o = valor_q;

endmodule

// File: rtl/arbitro_turnos.sv
// Two-player turn arbiter: accept->ack 1 cycle, full turn 6 cycles; off-turn requests wait.
// Turn timeout only when ARBITRO_TURNOS_TIMEOUT_EN is defined, otherwise ESPERA waits indefinitely.
module arbitro_turnos
    import arbitro_turnos_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int RODADAS        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 terminar,
    arbitro_turnos_if.slave      bus,
    output logic                 vez,
    output logic [2*BCD_W-1:0]   pontos1,
    output logic [2*BCD_W-1:0]   pontos2,
    output logic                 errou,
    output logic                 fim_partida,
    output logic [3:0]           db_estado
);

    estado_t    estado_q, estado_d;
    logic       vez_q, vez_d;
    logic [3:0] rodada_q, rodada_d;
    logic       hit_q, hit_d;
    logic [2:0] linha_q, linha_d;
    logic [2:0] coluna_q, coluna_d;

    logic       req_vez;
    logic [2:0] fil_vez;
    logic [2:0] col_vez;
    logic       expirou;
    logic       zera_pontos;
    logic       inc1;
    logic       inc2;

    assign req_vez = vez_q ? bus.jog2_req     : bus.jog1_req;
    assign fil_vez = vez_q ? bus.jog2_fileira : bus.jog1_fileira;
    assign col_vez = vez_q ? bus.jog2_coluna  : bus.jog1_coluna;

`ifdef ARBITRO_TURNOS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CICLOS);

    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (estado_q == NOVA) begin
            timer_d = '0;
        end else if (estado_q == ESPERA) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expirou = (timer_q == TMR_W'(TIMEOUT_CICLOS - 1));
`else
    assign expirou = 1'b0;
`endif

    always_comb begin
        estado_d    = estado_q;
        vez_d       = vez_q;
        rodada_d    = rodada_q;
        hit_d       = hit_q;
        linha_d     = linha_q;
        coluna_d    = coluna_q;
        zera_pontos = 1'b0;
        inc1        = 1'b0;
        inc2        = 1'b0;

        // Moore pulses decoded from the current state
        bus.zeraG     = (estado_q == PREPARA);
        bus.geraNova  = (estado_q == NOVA);
        bus.registraR = (estado_q == REGISTRA);
        bus.jog1_ack  = (estado_q == REGISTRA) && !vez_q;
        bus.jog2_ack  = (estado_q == REGISTRA) &&  vez_q;
        errou         = (estado_q == ATUALIZA) && !hit_q;

        if (terminar && estado_q != OCIOSO) begin
            estado_d = FIM;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) estado_d = PREPARA;
                end
                PREPARA: begin
                    zera_pontos = 1'b1;
                    vez_d       = 1'b0;
                    rodada_d    = '0;
                    estado_d    = NOVA;
                end
                NOVA: begin
                    estado_d = ESPERA;
                end
                ESPERA: begin
                    if (req_vez) begin
                        linha_d  = fil_vez;
                        coluna_d = col_vez;
                        estado_d = REGISTRA;
                    end else if (expirou) begin
                        hit_d    = 1'b0;
                        estado_d = ATUALIZA;
                    end
                end
                REGISTRA: begin
                    estado_d = COMPARA;
                end
                COMPARA: begin
                    hit_d    = bus.acertou;
                    estado_d = ATUALIZA;
                end
                ATUALIZA: begin
                    inc1     = hit_q && !vez_q;
                    inc2     = hit_q &&  vez_q;
                    estado_d = TROCA;
                end
                TROCA: begin
                    if (vez_q && rodada_q == 4'(RODADAS - 1)) begin
                        estado_d = FIM;
                    end else begin
                        if (vez_q) rodada_d = rodada_q + 4'd1;
                        vez_d    = !vez_q;
                        estado_d = NOVA;
                    end
                end
                FIM: begin
                    if (iniciar) estado_d = PREPARA;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            vez_q    <= 1'b0;
            rodada_q <= '0;
            hit_q    <= 1'b0;
            linha_q  <= '0;
            coluna_q <= '0;
        end else begin
            estado_q <= estado_d;
            vez_q    <= vez_d;
            rodada_q <= rodada_d;
            hit_q    <= hit_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
        end
    end

    contador_bcd2 u_pontos1 (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (zera_pontos),
        .inc_i   (inc1),
        .valor_o (pontos1)
    );

    contador_bcd2 u_pontos2 (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (zera_pontos),
        .inc_i   (inc2),
        .valor_o (pontos2)
    );

    assign bus.jogadaLinha  = linha_q;
    assign bus.jogadaColuna = coluna_q;
    assign vez              = vez_q;
    assign fim_partida      = (estado_q == FIM);
    assign db_estado        = estado_q;

endmodule

// File: tb/tb_arbitro_turnos.sv
// Directed bench for arbitro_turnos (RODADAS=2, TIMEOUT_CICLOS=10) plus a standalone
// contador_bcd2 for the 99 saturation case.
module tb_arbitro_turnos;
    import arbitro_turnos_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       terminar;
    logic       vez;
    logic [7:0] pontos1;
    logic [7:0] pontos2;
    logic       errou;
    logic       fim_partida;
    logic [3:0] db_estado;

    logic       cnt_clr;
    logic       cnt_inc;
    logic [7:0] cnt_valor;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    arbitro_turnos_if bus_if ();

    arbitro_turnos #(
        .TIMEOUT_CICLOS (10),
        .RODADAS        (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .terminar    (terminar),
        .bus         (bus_if),
        .vez         (vez),
        .pontos1     (pontos1),
        .pontos2     (pontos2),
        .errou       (errou),
        .fim_partida (fim_partida),
        .db_estado   (db_estado)
    );

    contador_bcd2 u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .valor_o (cnt_valor)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One accepted move from ESPERA; ends in ESPERA (next turn) or FIM when last.
    task automatic jogada(input bit p2, input logic [2:0] r, input logic [2:0] c,
                          input logic hit, input bit last,
                          input logic [7:0] exp1, input logic [7:0] exp2);
        verifica("move_vez", vez, p2);
        verifica("move_espera", db_estado, 4'd3);
        if (p2) begin
            bus_if.jog2_req = 1'b1; bus_if.jog2_fileira = r; bus_if.jog2_coluna = c;
        end else begin
            bus_if.jog1_req = 1'b1; bus_if.jog1_fileira = r; bus_if.jog1_coluna = c;
        end
        tick();
        verifica("move_ack",   p2 ? bus_if.jog2_ack : bus_if.jog1_ack, 1'b1);
        verifica("move_noack", p2 ? bus_if.jog1_ack : bus_if.jog2_ack, 1'b0);
        verifica("move_registraR", bus_if.registraR, 1'b1);
        verifica("move_linha", bus_if.jogadaLinha, r);
        verifica("move_coluna", bus_if.jogadaColuna, c);
        if (p2) bus_if.jog2_req = 1'b0;
        else    bus_if.jog1_req = 1'b0;
        bus_if.acertou = hit;
        tick();
        verifica("move_compara", db_estado, 4'd5);
        tick();
        verifica("move_atualiza", db_estado, 4'd6);
        verifica("move_errou", errou, !hit);
        tick();
        verifica("move_troca", db_estado, 4'd7);
        verifica("move_pontos1", pontos1, exp1);
        verifica("move_pontos2", pontos2, exp2);
        verifica("move_vez_troca", vez, p2);
        bus_if.acertou = 1'b0;
        tick();
        if (last) begin
            verifica("move_fim", db_estado, 4'd8);
            verifica("move_fim_partida", fim_partida, 1'b1);
        end else begin
            verifica("move_nova_vez", vez, !p2);
            verifica("move_geraNova", bus_if.geraNova, 1'b1);
            tick();
            verifica("move_nova_espera", db_estado, 4'd3);
        end
    endtask

    task automatic inicia_partida();
        iniciar = 1'b1;
        tick();
        verifica("ini_prepara", db_estado, 4'd1);
        verifica("ini_zeraG", bus_if.zeraG, 1'b1);
        iniciar = 1'b0;
        tick();
        verifica("ini_geraNova", bus_if.geraNova, 1'b1);
        verifica("ini_pontos1", pontos1, 8'h00);
        verifica("ini_pontos2", pontos2, 8'h00);
        tick();
        verifica("ini_espera", db_estado, 4'd3);
        verifica("ini_vez", vez, 1'b0);
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; terminar = 1'b0;
        cnt_clr = 1'b0; cnt_inc = 1'b0;
        bus_if.jog1_req = 1'b0; bus_if.jog1_fileira = '0; bus_if.jog1_coluna = '0;
        bus_if.jog2_req = 1'b0; bus_if.jog2_fileira = '0; bus_if.jog2_coluna = '0;
        bus_if.acertou = 1'b0;
        #2;
        verifica("rst_estado", db_estado, 4'd0);
        verifica("rst_pontos1", pontos1, 8'h00);
        verifica("rst_pontos2", pontos2, 8'h00);
        verifica("rst_vez", vez, 1'b0);
        verifica("rst_fim", fim_partida, 1'b0);
        verifica("rst_pulsos", {errou, bus_if.zeraG, bus_if.geraNova, bus_if.registraR,
                                bus_if.jog1_ack, bus_if.jog2_ack}, 6'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        verifica("ocioso_idle", db_estado, 4'd0);

        // Match 1: off-turn request held by player 2 while player 1 plays
        inicia_partida();
        bus_if.jog2_req = 1'b1; bus_if.jog2_fileira = 3'd3; bus_if.jog2_coluna = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            verifica("offturn_noack", bus_if.jog2_ack, 1'b0);
            verifica("offturn_espera", db_estado, 4'd3);
        end
        jogada(1'b0, 3'd5, 3'd2, 1'b1, 1'b0, 8'h01, 8'h00);
        jogada(1'b1, 3'd3, 3'd4, 1'b0, 1'b0, 8'h01, 8'h00);

`ifdef ARBITRO_TURNOS_TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick();
        verifica("tmo_antes_errou", errou, 1'b0);
        verifica("tmo_antes_estado", db_estado, 4'd3);
        tick();
        verifica("tmo_errou", errou, 1'b1);
        verifica("tmo_atualiza", db_estado, 4'd6);
        tick();
        verifica("tmo_pontos1", pontos1, 8'h01);
        tick();
        verifica("tmo_vez", vez, 1'b1);
        tick();
        verifica("tmo_espera", db_estado, 4'd3);
`else
        begin
            int n_errou;
            n_errou = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (errou) n_errou++;
            end
            verifica("semtmo_errou", n_errou, 0);
            verifica("semtmo_espera", db_estado, 4'd3);
        end
        jogada(1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 8'h01, 8'h00);
`endif
        jogada(1'b1, 3'd7, 3'd6, 1'b1, 1'b1, 8'h01, 8'h01);
        tick();
        verifica("fim_hold_estado", db_estado, 4'd8);
        verifica("fim_hold_pontos2", pontos2, 8'h01);

        // Match 2: every move correct
        inicia_partida();
        jogada(1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 8'h01, 8'h00);
        jogada(1'b1, 3'd2, 3'd3, 1'b1, 1'b0, 8'h01, 8'h01);
        jogada(1'b0, 3'd3, 3'd4, 1'b1, 1'b0, 8'h02, 8'h01);
        jogada(1'b1, 3'd4, 3'd5, 1'b1, 1'b1, 8'h02, 8'h02);
        verifica("m2_pontos1", pontos1, 8'h02);
        verifica("m2_pontos2", pontos2, 8'h02);

        // Match 3: abort on the same cycle as a valid request
        inicia_partida();
        bus_if.jog1_req = 1'b1; bus_if.jog1_fileira = 3'd6; bus_if.jog1_coluna = 3'd6;
        terminar = 1'b1;
        tick();
        verifica("term_fim", db_estado, 4'd8);
        verifica("term_noack", bus_if.jog1_ack, 1'b0);
        verifica("term_noreg", bus_if.registraR, 1'b0);
        verifica("term_linha", bus_if.jogadaLinha, 3'd4);
        iniciar = 1'b1;
        tick();
        verifica("term_sobre_iniciar", db_estado, 4'd8);
        iniciar = 1'b0; terminar = 1'b0; bus_if.jog1_req = 1'b0;

        // Reset mid-match, then iniciar+terminar together in OCIOSO
        inicia_partida();
        reset = 1'b0;
        #1;
        verifica("rst_meio_estado", db_estado, 4'd0);
        reset = 1'b1;
        tick();
        iniciar = 1'b1; terminar = 1'b1;
        tick();
        verifica("ocioso_ini_term", db_estado, 4'd1);
        iniciar = 1'b0;
        tick();
        verifica("term_prepara_fim", db_estado, 4'd8);
        terminar = 1'b0;

        // Score counter saturation
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        verifica("cnt_zero", cnt_valor, 8'h00);
        cnt_inc = 1'b1;
        for (int i = 0; i < 98; i++) tick();
        verifica("cnt_98", cnt_valor, 8'h98);
        tick();
        verifica("cnt_99", cnt_valor, 8'h99);
        tick();
        verifica("cnt_sat", cnt_valor, 8'h99);
        cnt_inc = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
